// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the 3-stage RV32I pipeline controller.
//   - RV32I opcode constants used by the controller
//   - PC_sel, forward-select and MemToReg encodings
//   - controller state enum and the per-stage instruction tag
//   - decode_tag(): builds a stage tag from the D-stage instruction fields
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_PLUS4  = 2'd1,
    PC_TARGET = 2'd2,
    PC_ZERO   = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_X  = 2'd1,
    FWD_M  = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    WB_PC4  = 2'd0,
    WB_ALU  = 2'd1,
    WB_DMEM = 2'd2,
    WB_UART = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    ST_RST,
    ST_FLUSH,
    ST_RUN,
    ST_MWAIT
  } state_e;

  typedef enum logic [2:0] {
    CL_NONE,
    CL_ALU,
    CL_JUMP,
    CL_BRANCH,
    CL_LOAD,
    CL_STORE
  } inst_class_e;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    inst_class_e cls;
    logic [2:0]  funct3;
  } stage_tag_t;

  function automatic logic writes_rd(inst_class_e c);
    return (c == CL_ALU) || (c == CL_JUMP) || (c == CL_LOAD);
  endfunction

  // rd is zeroed for classes that do not write it, so the immediate bits
  // that share the rd field in S/B formats can never cause a match.
  function automatic stage_tag_t decode_tag(logic [6:0] opc, logic [4:0] rd,
                                            logic [2:0] funct3);
    stage_tag_t t;
    t        = '0;
    t.valid  = 1'b1;
    t.funct3 = funct3;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_OPIMM, OPC_OP: t.cls = CL_ALU;
      OPC_JAL, OPC_JALR:                     t.cls = CL_JUMP;
      OPC_BRANCH:                            t.cls = CL_BRANCH;
      OPC_LOAD:                              t.cls = CL_LOAD;
      OPC_STORE:                             t.cls = CL_STORE;
      default:                               t.cls = CL_NONE;
    endcase
    if (writes_rd(t.cls)) t.rd = rd;
    return t;
  endfunction

endpackage

// File: rtl/riscv_fwd_unit.sv
// Combinational operand-forwarding and load-use detection.
//   opc_d, rs1_d, rs2_d : fields of the D-stage instruction
//   tag_x, tag_m        : X- and M-stage instruction tags
//   fwd_rs1, fwd_rs2    : 0 regfile, 1 X result, 2 M writeback
//   load_use            : X holds a load whose rd feeds the D instruction
module riscv_fwd_unit
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opc_d,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  stage_tag_t tag_x,
  input  stage_tag_t tag_m,
  output logic [1:0] fwd_rs1,
  output logic [1:0] fwd_rs2,
  output logic       load_use
);

  logic use_rs1, use_rs2;
  logic x_hit1, x_hit2, m_hit1, m_hit2;

  // Source usage is decided by opcode alone: I-type immediates occupy the
  // rs2 field and must not be mistaken for a register read.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opc_d)
      OPC_JALR, OPC_LOAD, OPC_OPIMM: use_rs1 = 1'b1;
      OPC_BRANCH, OPC_STORE, OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  function automatic logic hit(logic valid, logic [4:0] rd, logic [4:0] rs,
                               logic used);
    return used && valid && (rd != '0) && (rd == rs);
  endfunction

  assign x_hit1 = hit(tag_x.valid, tag_x.rd, rs1_d, use_rs1);
  assign x_hit2 = hit(tag_x.valid, tag_x.rd, rs2_d, use_rs2);
  assign m_hit1 = hit(tag_m.valid, tag_m.rd, rs1_d, use_rs1);
  assign m_hit2 = hit(tag_m.valid, tag_m.rd, rs2_d, use_rs2);

  assign fwd_rs1  = x_hit1 ? FWD_X : (m_hit1 ? FWD_M : FWD_RF);
  assign fwd_rs2  = x_hit2 ? FWD_X : (m_hit2 ? FWD_M : FWD_RF);
  assign load_use = (tag_x.cls == CL_LOAD) && (x_hit1 || x_hit2);

  logic unused_tag_bits;
  assign unused_tag_bits = ^{tag_x.funct3, tag_m.funct3, tag_m.cls};

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// Pipeline controller for the 3-stage RV32I datapath (D, X, M).
//   Clock, Reset       : clock, asynchronous active-high reset
//   inst_d             : instruction in D
//   branch_taken       : compare result for the X-stage branch
//   addr_m, mem_ready  : M-stage address, UART handshake
//   PC_sel             : 0 hold, 1 PC+4, 2 target, 3 zero
//   data_forward_ALU1/2: rs1/rs2 source select
//   stall_d, bubble_x  : hold D, inject NOP into X
//   RegWr, MemToReg    : writeback enable and source
//   dmem_we, uart_we   : store strobes
// Optional: define PIPE_CTRL_PERF_EN to add perf_cycles, perf_retired and
// perf_stalls counters (PERF_W bits, wrapping).
module riscv_pipe_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter logic [3:0]  UART_REGION = 4'h8,
  parameter int unsigned PERF_W      = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [31:0]       inst_d,
  input  logic              branch_taken,
  input  logic [31:0]       addr_m,
  input  logic              mem_ready,
  output logic [1:0]        PC_sel,
  output logic [1:0]        data_forward_ALU1,
  output logic [1:0]        data_forward_ALU2,
  output logic              stall_d,
  output logic              bubble_x,
  output logic              RegWr,
  output logic [1:0]        MemToReg,
  output logic [3:0]        dmem_we,
  output logic              uart_we
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_cycles,
  output logic [PERF_W-1:0] perf_retired,
  output logic [PERF_W-1:0] perf_stalls
`endif
);

  state_e     state;
  stage_tag_t tag_x, tag_m;

  logic active, m_mem, m_uart, freeze, redirect, lu_raw, load_use, m_go;

  riscv_fwd_unit u_fwd (
    .opc_d    (inst_d[6:0]),
    .rs1_d    (inst_d[19:15]),
    .rs2_d    (inst_d[24:20]),
    .tag_x    (tag_x),
    .tag_m    (tag_m),
    .fwd_rs1  (data_forward_ALU1),
    .fwd_rs2  (data_forward_ALU2),
    .load_use (lu_raw)
  );

  // MWAIT with mem_ready=1 behaves exactly like RUN, so both share one path.
  assign active   = (state == ST_RUN) || (state == ST_MWAIT);
  assign m_mem    = tag_m.valid && ((tag_m.cls == CL_LOAD) || (tag_m.cls == CL_STORE));
  assign m_uart   = m_mem && (addr_m[31:28] == UART_REGION);
  assign freeze   = active && m_uart && !mem_ready;
  assign redirect = active && !freeze && tag_x.valid &&
                    ((tag_x.cls == CL_JUMP) || ((tag_x.cls == CL_BRANCH) && branch_taken));
  assign load_use = active && !freeze && !redirect && lu_raw;
  assign m_go     = tag_m.valid && !freeze;

  always_comb begin
    PC_sel   = PC_PLUS4;
    stall_d  = 1'b0;
    bubble_x = 1'b0;
    case (state)
      ST_RST: begin
        PC_sel   = PC_ZERO;
        bubble_x = 1'b1;
      end
      ST_FLUSH: bubble_x = 1'b1;
      default: begin
        if (freeze) begin
          PC_sel  = PC_HOLD;
          stall_d = 1'b1;
        end else if (redirect) begin
          PC_sel   = PC_TARGET;
          bubble_x = 1'b1;
        end else if (load_use) begin
          PC_sel   = PC_HOLD;
          stall_d  = 1'b1;
          bubble_x = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    RegWr    = m_go && (tag_m.rd != '0) && writes_rd(tag_m.cls);
    MemToReg = WB_PC4;
    if (tag_m.valid) begin
      case (tag_m.cls)
        CL_JUMP: MemToReg = WB_PC4;
        CL_LOAD: MemToReg = m_uart ? WB_UART : WB_DMEM;
        default: MemToReg = WB_ALU;
      endcase
    end
    uart_we = m_go && (tag_m.cls == CL_STORE) && m_uart;
    dmem_we = '0;
    if (m_go && (tag_m.cls == CL_STORE) && !m_uart) begin
      case (tag_m.funct3[1:0])
        2'b00:   dmem_we = 4'b0001 << addr_m[1:0];
        2'b01:   dmem_we = 4'b0011 << {addr_m[1], 1'b0};
        default: dmem_we = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= ST_RST;
      tag_x <= '0;
      tag_m <= '0;
    end else begin
      case (state)
        ST_RST:   state <= ST_FLUSH;
        ST_FLUSH: state <= ST_RUN;
        default:  state <= freeze ? ST_MWAIT : (redirect ? ST_FLUSH : ST_RUN);
      endcase
      if (!freeze) begin
        tag_m <= tag_x;
        if (bubble_x) tag_x <= '0;
        else          tag_x <= decode_tag(inst_d[6:0], inst_d[11:7], inst_d[14:12]);
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      perf_cycles  <= '0;
      perf_retired <= '0;
      perf_stalls  <= '0;
    end else begin
      perf_cycles <= perf_cycles + PERF_W'(1);
      if (m_go) perf_retired <= perf_retired + PERF_W'(1);
      if (load_use || freeze || (state == ST_FLUSH)) perf_stalls <= perf_stalls + PERF_W'(1);
    end
  end
`else
  // PERF_W only sizes the optional counters.
  if (PERF_W < 1) begin : g_perf_w_unused
  end
`endif

  logic unused_bits;
  assign unused_bits = ^{inst_d[31:25], addr_m[27:2], tag_x.funct3, tag_m.funct3[2]};

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
module tb_riscv_pipe_ctrl;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] inst_d = 32'h0000_0013;
  logic        branch_taken = 1'b0;
  logic [31:0] addr_m = '0;
  logic        mem_ready = 1'b1;
  logic [1:0]  PC_sel, data_forward_ALU1, data_forward_ALU2, MemToReg;
  logic        stall_d, bubble_x, RegWr, uart_we;
  logic [3:0]  dmem_we;

  riscv_pipe_ctrl #(.UART_REGION(4'h8), .PERF_W(32)) dut (
    .Clock(Clock), .Reset(Reset), .inst_d(inst_d), .branch_taken(branch_taken),
    .addr_m(addr_m), .mem_ready(mem_ready), .PC_sel(PC_sel),
    .data_forward_ALU1(data_forward_ALU1), .data_forward_ALU2(data_forward_ALU2),
    .stall_d(stall_d), .bubble_x(bubble_x), .RegWr(RegWr), .MemToReg(MemToReg),
    .dmem_we(dmem_we), .uart_we(uart_we)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: raw instruction words sitting in X and M.
  localparam int M_RST = 0, M_FLUSH = 1, M_RUN = 2, M_WAIT = 3;
  int          mst;
  bit          xv, mv;
  logic [31:0] xi, mi;

  function automatic bit is_load(logic [31:0] i);   return i[6:0] == 7'h03; endfunction
  function automatic bit is_store(logic [31:0] i);  return i[6:0] == 7'h23; endfunction
  function automatic bit is_jump(logic [31:0] i);   return i[6:0] == 7'h6f || i[6:0] == 7'h67; endfunction
  function automatic bit is_branch(logic [31:0] i); return i[6:0] == 7'h63; endfunction

  function automatic bit writes(logic [31:0] i);
    bit w;
    w = i[6:0] inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h13, 7'h33, 7'h03};
    return w && (i[11:7] != 5'd0);
  endfunction
  function automatic bit uses1(logic [31:0] i);
    return i[6:0] inside {7'h67, 7'h03, 7'h13, 7'h23, 7'h63, 7'h33};
  endfunction
  function automatic bit uses2(logic [31:0] i);
    return i[6:0] inside {7'h23, 7'h63, 7'h33};
  endfunction

  function automatic logic [1:0] fsel(logic [4:0] rs, bit used);
    if (used && xv && writes(xi) && xi[11:7] == rs) return 2'd1;
    if (used && mv && writes(mi) && mi[11:7] == rs) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    r   = $urandom;
    rd  = 5'($urandom_range(0, 3));
    rs1 = 5'($urandom_range(0, 3));
    rs2 = 5'($urandom_range(0, 3));
    f3  = 3'($urandom_range(0, 2));
    case ($urandom_range(0, 10))
      0:       return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};       // add
      1:       return {r[31:20], rs1, 3'b000, rd, 7'h13};         // addi
      2, 3:    return {r[31:20], rs1, 3'b010, rd, 7'h03};         // lw
      4, 5:    return {r[31:25], rs2, rs1, f3, r[11:7], 7'h23};   // sb/sh/sw
      6:       return {r[31:25], rs2, rs1, 3'b000, r[11:7], 7'h63}; // beq
      7:       return {r[31:12], rd, 7'h6f};                      // jal
      8:       return {r[31:20], rs1, 3'b000, rd, 7'h67};         // jalr
      9:       return {r[31:12], rd, 7'h37};                      // lui
      default: return {r[31:7], 7'h0f};                           // fence
    endcase
  endfunction

  function automatic logic [31:0] gen_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 2) == 0) a[31:28] = 4'h8;
    else if (a[31:28] == 4'h8)     a[31:28] = 4'h0;
    return a;
  endfunction

  initial begin
    bit          hold_d, hold_m, wait_c, redir, lu, m_uart;
    logic [1:0]  e_pc, e_f1, e_f2, e_mtr;
    logic        e_st, e_bx, e_rw, e_uwe;
    logic [3:0]  e_dwe;
    hold_d = 0; hold_m = 0;
    mst = M_RST; xv = 0; mv = 0; xi = '0; mi = '0;
    repeat (2) @(negedge Clock);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge Clock);
      Reset = (cyc < 2) || ($urandom_range(0, 99) == 0);
      if (!hold_d) inst_d = gen_inst();
      if (!hold_m) addr_m = gen_addr();
      branch_taken = 1'($urandom_range(0, 1));
      mem_ready    = ($urandom_range(0, 2) != 0);
      #1;
      if (Reset) begin mst = M_RST; xv = 0; mv = 0; end

      e_pc = 2'd1; e_st = 0; e_bx = 0; wait_c = 0; redir = 0; lu = 0;
      m_uart = mv && (is_load(mi) || is_store(mi)) && (addr_m[31:28] == 4'h8);
      if (mst == M_RST) begin
        e_pc = 2'd3; e_bx = 1;
      end else if (mst == M_FLUSH) begin
        e_bx = 1;
      end else begin
        wait_c = m_uart && !mem_ready;
        redir  = xv && (is_jump(xi) || (is_branch(xi) && branch_taken));
        lu     = xv && is_load(xi) && xi[11:7] != 5'd0 &&
                 ((uses1(inst_d) && inst_d[19:15] == xi[11:7]) ||
                  (uses2(inst_d) && inst_d[24:20] == xi[11:7]));
        if (wait_c)     begin e_pc = 2'd0; e_st = 1; end
        else if (redir) begin e_pc = 2'd2; e_bx = 1; end
        else if (lu)    begin e_pc = 2'd0; e_st = 1; e_bx = 1; end
      end
      e_f1 = fsel(inst_d[19:15], uses1(inst_d));
      e_f2 = fsel(inst_d[24:20], uses2(inst_d));
      e_rw = mv && !wait_c && writes(mi);
      if (!mv || is_jump(mi)) e_mtr = 2'd0;
      else if (is_load(mi))   e_mtr = m_uart ? 2'd3 : 2'd2;
      else                    e_mtr = 2'd1;
      e_dwe = 4'd0; e_uwe = 0;
      if (mv && !wait_c && is_store(mi)) begin
        if (m_uart) e_uwe = 1;
        else if (mi[13:12] == 2'd0) e_dwe = 4'b0001 << addr_m[1:0];
        else if (mi[13:12] == 2'd1) e_dwe = 4'b0011 << (2 * addr_m[1]);
        else e_dwe = 4'b1111;
      end

      check("PC_sel", 32'(PC_sel), 32'(e_pc));
      check("stall_d", 32'(stall_d), 32'(e_st));
      check("bubble_x", 32'(bubble_x), 32'(e_bx));
      check("fwd1", 32'(data_forward_ALU1), 32'(e_f1));
      check("fwd2", 32'(data_forward_ALU2), 32'(e_f2));
      check("RegWr", 32'(RegWr), 32'(e_rw));
      check("MemToReg", 32'(MemToReg), 32'(e_mtr));
      check("dmem_we", 32'(dmem_we), 32'(e_dwe));
      check("uart_we", 32'(uart_we), 32'(e_uwe));

      // What the next rising edge does to the pipe.
      if (Reset) begin
        mst = M_RST; xv = 0; mv = 0;
      end else if (mst == M_RST || mst == M_FLUSH) begin
        mst = (mst == M_RST) ? M_FLUSH : M_RUN;
        mv = xv; mi = xi; xv = 0;
      end else if (wait_c) begin
        mst = M_WAIT;
      end else begin
        mst = redir ? M_FLUSH : M_RUN;
        mv = xv; mi = xi;
        xv = !(redir || lu); xi = inst_d;
      end
      hold_d = e_st;
      hold_m = wait_c;
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_pipe_ctrl.md
Name: riscv_pipe_ctrl

Overview:
- Pipeline controller for the 3-stage RV32I datapath: D (decode/regfile read), X (ALU, branch resolve) and M (memory, writeback).
- Tracks the rd, class and funct3 of the X- and M-stage instructions.
- Generates PC select, forwarding selects, load-use stalls, redirect flushes, writeback and memory-write enables.
- Freezes the pipe while a UART access is not ready.

Parameters:
- UART_REGION, 4'h8, address bits [31:28] value that selects UART instead of dmem.
- PERF_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- Clock  in  1  sole clock.
- Reset  in  1  asynchronous, active-high reset.
- inst_d  in  32  instruction currently in D (BRAM dout).
- branch_taken  in  1  branch compare result for the X-stage instruction.
- addr_m  in  32  address of the M-stage instruction (ALU result registered into M).
- mem_ready  in  1  UART access in M may complete this cycle.
- PC_sel  out  2  0 hold, 1 PC+4, 2 target, 3 zero.
- data_forward_ALU1  out  2  rs1 source: 0 regfile, 1 X result, 2 M writeback.
- data_forward_ALU2  out  2  rs2 source, same encoding as data_forward_ALU1.
- stall_d  out  1  hold the D register / instruction.
- bubble_x  out  1  load a NOP into X instead of the D instruction.
- RegWr  out  1  regfile write enable for the M-stage rd.
- MemToReg  out  2  writeback source: 0 PC+4, 1 ALU, 2 dmem, 3 UART.
- dmem_we  out  4  dmem byte write mask.
- uart_we  out  1  UART write strobe.

Behaviour:
- Reset (async, effective immediately):
  - State RST.
  - X and M valid cleared.
  - Outputs: PC_sel=3, bubble_x=1, stall_d=0, forwards=0, RegWr=0, MemToReg=0, dmem_we=0, uart_we=0.
- State machine, in priority order:
  - RST: PC_sel=3, bubble_x=1. Next state FLUSH.
  - FLUSH: PC_sel=1, bubble_x=1 (discards the stale BRAM word). Next state RUN.
  - RUN, M is a UART load/store (addr_m[31:28]==UART_REGION) with mem_ready=0: PC_sel=0, stall_d=1, X and M held, RegWr=0, uart_we=0. Next state MWAIT.
  - RUN, X holds JAL, JALR, or a branch with branch_taken=1: PC_sel=2, bubble_x=1. Next state FLUSH.
  - RUN, load-use hazard (X is a load, rd_x≠0, rd_x equals a source register of inst_d): PC_sel=0, stall_d=1, bubble_x=1. Stays RUN. The next cycle the load is in M and forward select 2 applies.
  - RUN, otherwise: PC_sel=1.
  - MWAIT: same outputs as the UART-wait case in RUN while mem_ready=0. On mem_ready=1, perform the M action and return to RUN. Redirect and load-use checks are re-evaluated in that cycle.
- Simultaneous events: MWAIT beats redirect, and redirect beats load-use.
- Reset asserted mid-MWAIT or mid-FLUSH: returns to RST with no write strobes issued.
- Forwarding (combinational from inst_d, X and M tags):
  - X match selects 1; else M match selects 2; else 0.
  - rd=0 never matches.
  - An invalid stage never matches.
  - Source registers are decoded per opcode only: U/J formats have none; I format has rs1 only.
- Writeback (M stage):
  - RegWr=1 when M valid, rd≠0, and the class writes rd, qualified by no UART wait.
  - MemToReg: 0 for JAL/JALR; 2 for a load from dmem; 3 for a load from UART; 1 otherwise.
- Stores (M stage):
  - UART region: uart_we=1, dmem_we=0.
  - Otherwise: SB gives 4'b0001<<addr_m[1:0]; SH gives 4'b0011<<{addr_m[1],1'b0}; SW gives 4'b1111.
  - Misaligned SH/SW: mask still computed from the aligned bits; no trap.
- Tag advance:
  - X tag is loaded from inst_d unless bubble_x or a freeze applies.
  - M tag is loaded from X unless frozen.
  - Valid=0 entries produce no writes and no matches.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined, adds outputs perf_cycles, perf_retired, perf_stalls, each PERF_W bits.
  - perf_cycles increments every cycle out of reset.
  - perf_retired increments when a valid M instruction completes.
  - perf_stalls increments on load-use, MWAIT and FLUSH cycles.
  - All counters wrap on overflow and clear on Reset.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP);
  - PC_sel, forward and MemToReg encodings;
  - the state enum (RST, FLUSH, RUN, MWAIT);
  - the stage tag struct {valid, rd, class, funct3}.
- Sub-module riscv_fwd_unit: purely combinational rs1/rs2 decode, compare and forward select, also emitting the load-use flag.

Test Plan:
- Reset released: PC_sel sequence is 3, 1 (FLUSH, bubble_x=1), then 1 in RUN; no RegWr before the first valid M instruction.
- addi x1,x0,5 followed by add x2,x1,x1: data_forward_ALU1=1 and data_forward_ALU2=1 in the add's D cycle; with one independent instruction between them, both selects are 2.
- lw x3,0(x0) followed by add x4,x3,x0: one cycle with PC_sel=0, stall_d=1, bubble_x=1, then data_forward_ALU1=2; MemToReg=2 and RegWr=1 for the lw.
- beq taken in X: PC_sel=2 with bubble_x=1, then FLUSH (bubble_x=1); the two wrong-path instructions never assert RegWr or dmem_we.
- sb to addr 0x00000006 gives dmem_we=4'b0100. sw to 0x80000008 with mem_ready held 0 for 3 cycles: PC_sel=0 and uart_we=0 for 3 cycles, then uart_we=1 on the cycle mem_ready=1.
- Reset asserted during MWAIT: outputs return to their reset values immediately; no uart_we pulse follows.
